// File: rtl/systolic_array.sv
// DIM x DIM signed MAC grid: A shifts right, B shifts down, each PE accumulates A*B.
// One accumulator row, picked by Crow, is read out on Cout or preloaded from Cin.
`timescale 1ns/1ps
module systolic_array #(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16,
  parameter int DIM     = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        WrEn,
  input  logic [DIM-1:0][BITS_AB-1:0] A,
  input  logic [DIM-1:0][BITS_AB-1:0] B,
  input  logic [DIM-1:0][BITS_C-1:0]  Cin,
  input  logic [$clog2(DIM)-1:0]      Crow,
  output logic [DIM-1:0][BITS_C-1:0]  Cout
);
  localparam int PW = (BITS_C > 2 * BITS_AB) ? BITS_C : 2 * BITS_AB;
  localparam int RW = $clog2(DIM);

  logic [BITS_AB-1:0] a_s   [DIM][DIM];
  logic [BITS_AB-1:0] b_s   [DIM][DIM];
  logic [BITS_C-1:0]  acc_s [DIM][DIM];

  for (genvar r = 0; r < DIM; r++) begin : g_row
    for (genvar c = 0; c < DIM; c++) begin : g_col
      logic [BITS_AB-1:0] a_in, b_in;
      logic [BITS_AB-1:0] a_q, a_d, b_q, b_d;
      logic [BITS_C-1:0]  acc_q, acc_d;
      logic signed [PW-1:0] prod;
      logic row_wr;

      if (c == 0) begin : g_a_edge
        assign a_in = A[r];
      end else begin : g_a_hop
        assign a_in = a_s[r][c-1];
      end

      if (r == 0) begin : g_b_edge
        assign b_in = B[c];
      end else begin : g_b_hop
        assign b_in = b_s[r-1][c];
      end

      // Operands widened before the multiply so the full signed product survives.
      assign prod   = PW'($signed(a_in)) * PW'($signed(b_in));
      assign row_wr = WrEn && (Crow == RW'(r));

      // Next-state: a preload beats accumulation for this row; operands shift independently.
      always_comb begin
        acc_d = acc_q;
        a_d   = a_q;
        b_d   = b_q;
        if (row_wr) begin
          acc_d = Cin[c];
        end else if (en) begin
          acc_d = acc_q + prod[BITS_C-1:0];
        end else begin
          acc_d = acc_q;
        end
        if (en) begin
          a_d = a_in;
          b_d = b_in;
        end else begin
          a_d = a_q;
          b_d = b_q;
        end
      end

      // PE state registers.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q   <= '0;
          b_q   <= '0;
          acc_q <= '0;
        end else begin
          a_q   <= a_d;
          b_q   <= b_d;
          acc_q <= acc_d;
        end
      end

      assign a_s[r][c]   = a_q;
      assign b_s[r][c]   = b_q;
      assign acc_s[r][c] = acc_q;
    end
  end

  for (genvar c = 0; c < DIM; c++) begin : g_out
    assign Cout[c] = acc_s[Crow][c];
  end

endmodule

// File: tb/tb_systolic_array.sv
// Self-checking bench for systolic_array: operand-history reference model plus
// direct matrix-product expectations, with randomized operands and control.
`timescale 1ns/1ps
module tb_systolic_array;
  localparam int MAXT = 512;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en = 1'b0;
  logic            WrEn = 1'b0;
  logic [7:0][7:0]  A = '0;
  logic [7:0][7:0]  B = '0;
  logic [7:0][15:0] Cin = '0;
  logic [2:0]       Crow = 3'd0;
  logic [7:0][15:0] Cout;

  systolic_array #(.BITS_AB(8), .BITS_C(16), .DIM(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .WrEn(WrEn),
    .A(A), .B(B), .Cin(Cin), .Crow(Crow), .Cout(Cout)
  );

  always #10 clk = ~clk;

  logic signed [7:0]  a_drv [8];
  logic signed [7:0]  b_drv [8];
  logic signed [15:0] cin_drv [8];
  int am [8][8];
  int bm [8][8];
  int macc [8][8];
  int ah [MAXT][8];
  int bh [MAXT][8];
  int tcnt;
  int n_checks = 0;
  int n_fail = 0;

  function automatic int wrap16(input int x);
    logic signed [15:0] v;
    v = x[15:0];
    return int'(v);
  endfunction

  task automatic clear_model();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) macc[r][c] = 0;
    tcnt = 0;
  endtask

  task automatic zero_drv();
    for (int i = 0; i < 8; i++) begin
      a_drv[i] = 8'sd0; b_drv[i] = 8'sd0; cin_drv[i] = 16'sd0;
    end
  endtask

  task automatic rand_drv();
    for (int i = 0; i < 8; i++) begin
      a_drv[i] = 8'($urandom); b_drv[i] = 8'($urandom); cin_drv[i] = 16'($urandom);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Model: an operand entering at en-cycle t reaches PE(r,c) after c (A) or r (B) en-cycles.
  task automatic step(input bit e, input bit w, input int row);
    int av, bv;
    for (int i = 0; i < 8; i++) begin
      A[i] = a_drv[i]; B[i] = b_drv[i]; Cin[i] = cin_drv[i];
    end
    en = e; WrEn = w; Crow = 3'(row);
    if (e) begin
      if (tcnt >= MAXT) $fatal(1, "FAIL history: tcnt=%0d exceeds %0d", tcnt, MAXT);
      for (int i = 0; i < 8; i++) begin
        ah[tcnt][i] = int'(a_drv[i]); bh[tcnt][i] = int'(b_drv[i]);
      end
    end
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        if (w && r == row) macc[r][c] = int'(cin_drv[c]);
        else if (e) begin
          av = (tcnt >= c) ? ah[tcnt-c][r] : 0;
          bv = (tcnt >= r) ? bh[tcnt-r][c] : 0;
          macc[r][c] = wrap16(macc[r][c] + av * bv);
        end
      end
    if (e) tcnt++;
    @(posedge clk);
    #1;
    en = 1'b0; WrEn = 1'b0;
  endtask

  // Skewed feed of am x bm: row r / column c delayed by r / c cycles.
  task automatic drive_matmul(input int ncyc, input bit bubbles);
    int k;
    for (int t = 0; t < ncyc; t++) begin
      if (bubbles && ($urandom % 3) == 0) begin
        rand_drv();
        step(1'b0, 1'b0, 0);
      end
      zero_drv();
      for (int i = 0; i < 8; i++) begin
        k = t - i;
        if (k >= 0 && k < 8) begin
          a_drv[i] = 8'(am[i][k]); b_drv[i] = 8'(bm[k][i]);
        end
      end
      step(1'b1, 1'b0, 0);
    end
  endtask

  task automatic test_reset();
    clear_model();
    #25;
    rst_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      rand_drv();
      step(1'b0, 1'b0, 0);
    end
    for (int r = 0; r < 8; r++) begin
      Crow = 3'(r); #1;
      for (int c = 0; c < 8; c++) begin
        n_checks++;
        if (Cout[c] !== 16'd0) begin
          n_fail++;
          $display("FAIL reset_idle row%0d col%0d: got %0d expected 0", r, c, $signed(Cout[c]));
        end
      end
    end
  endtask

  task automatic test_single_hop();
    do_reset();
    zero_drv();
    a_drv[0] = 8'sd3; b_drv[0] = 8'sd4;
    step(1'b1, 1'b0, 0);
    Crow = 3'd0; #1;
    n_checks++;
    if ($signed(Cout[0]) !== 16'sd12) begin
      n_fail++; $display("FAIL single_hop_pe00: got %0d expected 12", $signed(Cout[0]));
    end
    zero_drv();
    step(1'b1, 1'b0, 0);
    Crow = 3'd0; #1;
    n_checks++;
    if ($signed(Cout[1]) !== 16'sd0) begin
      n_fail++; $display("FAIL single_hop_pe01: got %0d expected 0", $signed(Cout[1]));
    end
    n_checks++;
    if ($signed(Cout[0]) !== 16'sd12) begin
      n_fail++; $display("FAIL single_hop_hold: got %0d expected 12", $signed(Cout[0]));
    end
  endtask

  task automatic test_signed_wrap();
    do_reset();
    zero_drv();
    cin_drv[0] = 16'sd32767;
    step(1'b0, 1'b1, 0);
    Crow = 3'd0; #1;
    n_checks++;
    if ($signed(Cout[0]) !== 16'sd32767) begin
      n_fail++; $display("FAIL preload: got %0d expected 32767", $signed(Cout[0]));
    end
    zero_drv();
    a_drv[0] = 8'sd1; b_drv[0] = 8'sd1;
    step(1'b1, 1'b0, 0);
    Crow = 3'd0; #1;
    n_checks++;
    if (int'($signed(Cout[0])) !== -32768) begin
      n_fail++; $display("FAIL wrap: got %0d expected -32768", $signed(Cout[0]));
    end
    do_reset();
    zero_drv();
    a_drv[0] = -8'sd128; b_drv[0] = -8'sd128;
    step(1'b1, 1'b0, 0);
    Crow = 3'd0; #1;
    n_checks++;
    if (int'($signed(Cout[0])) !== 16384) begin
      n_fail++; $display("FAIL neg_product: got %0d expected 16384", $signed(Cout[0]));
    end
  endtask

  task automatic test_matmul_identity();
    do_reset();
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        am[i][j] = (i == j) ? 1 : 0; bm[i][j] = i * 8 + j;
      end
    drive_matmul(22, 1'b0);
    for (int r = 0; r < 8; r++) begin
      Crow = 3'(r); #1;
      for (int c = 0; c < 8; c++) begin
        n_checks++;
        if (Cout[c] !== 16'(r * 8 + c)) begin
          n_fail++;
          $display("FAIL matmul_identity row%0d col%0d: got %0d expected %0d", r, c, $signed(Cout[c]), r * 8 + c);
        end
      end
    end
  endtask

  task automatic test_matmul_random();
    int exp_v;
    do_reset();
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        am[i][j] = int'($urandom_range(0, 255)) - 128;
        bm[i][j] = int'($urandom_range(0, 255)) - 128;
      end
    drive_matmul(22, 1'b1);
    for (int r = 0; r < 8; r++) begin
      Crow = 3'(r); #1;
      for (int c = 0; c < 8; c++) begin
        exp_v = 0;
        for (int k = 0; k < 8; k++) exp_v += am[r][k] * bm[k][c];
        exp_v = wrap16(exp_v);
        n_checks++;
        if (int'($signed(Cout[c])) !== exp_v) begin
          n_fail++;
          $display("FAIL matmul_random row%0d col%0d: got %0d expected %0d", r, c, $signed(Cout[c]), exp_v);
        end
      end
    end
  endtask

  task automatic test_collision();
    do_reset();
    for (int n = 0; n < 5; n++) begin
      rand_drv();
      step(1'b1, 1'b0, 0);
    end
    rand_drv();
    for (int i = 0; i < 8; i++) begin
      cin_drv[i] = 16'sd7;
      if (a_drv[i] == 8'sd0) a_drv[i] = 8'sd5;
      if (b_drv[i] == 8'sd0) b_drv[i] = -8'sd3;
    end
    step(1'b1, 1'b1, 2);
    for (int r = 0; r < 4; r++) begin
      Crow = 3'(r); #1;
      for (int c = 0; c < 8; c++) begin
        n_checks++;
        if (r == 2 && Cout[c] !== 16'd7) begin
          n_fail++; $display("FAIL collision_row2 col%0d: got %0d expected 7", c, $signed(Cout[c]));
        end else if (r != 2 && Cout[c] !== 16'(macc[r][c])) begin
          n_fail++;
          $display("FAIL collision_other row%0d col%0d: got %0d expected %0d", r, c, $signed(Cout[c]), macc[r][c]);
        end
      end
    end
    rand_drv();
    step(1'b1, 1'b0, 0);
    Crow = 3'd3; #1;
    for (int c = 0; c < 8; c++) begin
      n_checks++;
      if (Cout[c] !== 16'(macc[3][c])) begin
        n_fail++;
        $display("FAIL collision_shift row3 col%0d: got %0d expected %0d", c, $signed(Cout[c]), macc[3][c]);
      end
    end
  endtask

  task automatic test_random_stream();
    int row;
    do_reset();
    for (int n = 0; n < 150; n++) begin
      rand_drv();
      step(($urandom % 4) != 0, ($urandom % 5) == 0, int'($urandom_range(0, 7)));
      row = int'($urandom_range(0, 7));
      Crow = 3'(row); #1;
      for (int c = 0; c < 8; c++) begin
        n_checks++;
        if (Cout[c] !== 16'(macc[row][c])) begin
          n_fail++;
          $display("FAIL random_stream step%0d row%0d col%0d: got %0d expected %0d", n, row, c, $signed(Cout[c]), macc[row][c]);
        end
      end
    end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        am[i][j] = (i == j) ? 1 : 0; bm[i][j] = i * 8 + j;
      end
    drive_matmul(11, 1'b0);
    #2;
    rst_n = 1'b0;
    for (int r = 0; r < 8; r++) begin
      Crow = 3'(r); #0.5;
      for (int c = 0; c < 8; c++) begin
        n_checks++;
        if (Cout[c] !== 16'd0) begin
          n_fail++; $display("FAIL midrun_reset row%0d col%0d: got %0d expected 0", r, c, $signed(Cout[c]));
        end
      end
    end
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    drive_matmul(22, 1'b0);
    for (int r = 0; r < 8; r++) begin
      Crow = 3'(r); #1;
      for (int c = 0; c < 8; c++) begin
        n_checks++;
        if (Cout[c] !== 16'(r * 8 + c)) begin
          n_fail++;
          $display("FAIL midrun_rerun row%0d col%0d: got %0d expected %0d", r, c, $signed(Cout[c]), r * 8 + c);
        end
      end
    end
  endtask

  initial begin
    zero_drv();
    test_reset();
    test_single_hop();
    test_signed_wrap();
    test_matmul_identity();
    test_matmul_random();
    test_collision();
    test_random_stream();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_array.md
Name: systolic_array

Overview:
- DIM x DIM signed multiply-accumulate grid that consumes the per-row A and per-column B streams produced by the upstream transpose FIFOs (one FIFO q per row/column).
- Each processing element (PE) multiplies its A and B operands and accumulates the product locally. It also forwards A to the right and B downward, one cycle per hop.
- Accumulated results are read out, and preloaded, one row at a time for the downstream result path.

Parameters:
BITS_AB, 8, signed width of A and B operands
BITS_C, 16, signed width of each accumulator and of Cin/Cout
DIM, 8, array dimension (rows = columns = DIM)

Ports:
clk  input  1  clock; all state updates on posedge
rst_n  input  1  asynchronous active-low reset
en  input  1  advance: accumulate and shift operands one hop
WrEn  input  1  load Cin into accumulator row Crow
A  input  BITS_AB x DIM  signed; A[r] enters PE(r,0); driven by row-r FIFO q
B  input  BITS_AB x DIM  signed; B[c] enters PE(0,c); driven by column-c FIFO q
Cin  input  BITS_C x DIM  signed; write data for accumulator row Crow
Crow  input  $clog2(DIM)  row select for WrEn and for Cout
Cout  output  BITS_C x DIM  signed; Cout[c] = accumulator of PE(Crow,c), combinational

Behaviour:
- One clock and one reset: clk, rst_n. Reset is asynchronous and active-low.
- Reset clears every PE accumulator and every A/B forwarding register to 0. Cout therefore reads 0 after reset.
- Per PE(r,c), the state is acc (BITS_C), a_reg (BITS_AB) and b_reg (BITS_AB).
- Operand in: a_in = A[r] when c==0, else a_reg of PE(r,c-1). b_in = B[c] when r==0, else b_reg of PE(r-1,c).
- On posedge with en=1, each PE updates: acc <= acc + sext(a_in*b_in); a_reg <= a_in; b_reg <= b_in.
- Arithmetic: full signed product (2*BITS_AB bits), sign-extended or truncated to BITS_C. The sum wraps modulo 2^BITS_C with no saturation and no overflow flag.
- en=0: all state holds. A and B values presented while en=0 are ignored.
- WrEn=1: every PE in row Crow loads acc <= Cin[c] on the edge.
  - WrEn has priority over en for that row's accumulators only; the accumulate term for row Crow is discarded.
  - a_reg/b_reg in row Crow still shift when en=1.
  - All other rows accumulate normally when en=1.
- Crow out of range is impossible because DIM is a power of two. Non-power-of-two DIM is not supported.
- Latency: an operand entering at the row/column edge reaches PE(r,c) after r or c en-cycles.
- Skew: the upstream FIFOs provide the skew, with row r / column k data delayed by r / k cycles. This block applies no skew.
- Full C = A x B needs 3*DIM-2 en-cycles after the first operand, followed by zero-padding.
- Cout is purely combinational from the accumulators and Crow. A write is visible on Cout the cycle after the WrEn edge.
- Reset asserted mid-computation clears all state immediately, without waiting for clk. Operation resumes on the first edge after rst_n rises.

Test Plan:
- Reset then idle: rst_n low, then high, en=0 for 5 cycles -> Cout=0 for every Crow in 0..7.
- Single hop: A[0]=3, B[0]=4, en=1 for one cycle, then A=B=0, en=1 for one more cycle.
  - PE(0,0) acc=12 (Crow=0 -> Cout[0]=12).
  - After the second cycle PE(0,1) gets a_in=3 with b_in=B[1]=0 -> Cout[1]=0.
- Signed/wrap:
  - Preload row 0 with Cin[0]=32767 via WrEn, then A[0]=1, B[0]=1, en=1 -> Cout[0]=-32768.
  - Separately, from acc=0 with A=-128, B=-128 -> acc=16384.
- Full matmul, DIM=8, skewed identity A x B where B[i][j]=i*8+j:
  - Drive 3*DIM-2 en-cycles with zero padding.
  - Sweep Crow 0..7 -> Cout equals row i of B.
- WrEn/en collision:
  - Crow=2, WrEn=1, en=1, Cin all 7, nonzero A/B -> row 2 acc=7 (product dropped).
  - Rows 0/1/3 accumulated.
  - a_reg/b_reg advanced, checked by the next-cycle products in row 3.
- Reset mid-run: assert rst_n low asynchronously halfway through the matmul -> all Cout=0 before the next clk edge. Rerun from scratch gives the correct result.
